// File: rtl/burst_stream_gen_if.sv
// Control/data bundle between a burst_stream_gen and whatever programs and consumes it.
// master = controller side (programs pattern, issues start); slave = the generator itself.
interface burst_stream_gen_if #(
    parameter int WORD_LEN  = 8,
    parameter int PAT_DEPTH = 16,
    parameter int CNT_W     = 8
);
    localparam int AW = $clog2(PAT_DEPTH);

    logic                pat_we;
    logic [AW-1:0]       pat_addr;
    logic [WORD_LEN-1:0] pat_wdat;
    logic [AW:0]         pat_len;
    logic [CNT_W-1:0]    burst_len;
    logic [CNT_W-1:0]    gap_len;
    logic [CNT_W-1:0]    num_bursts;
    logic                start;
    logic [WORD_LEN-1:0] dat_o;
    logic                val_o;
    logic                busy;
    logic                done;

    modport master (
        output pat_we, pat_addr, pat_wdat, pat_len, burst_len, gap_len, num_bursts, start,
        input  dat_o, val_o, busy, done
    );

    modport slave (
        input  pat_we, pat_addr, pat_wdat, pat_len, burst_len, gap_len, num_bursts, start,
        output dat_o, val_o, busy, done
    );
endinterface

// File: rtl/burst_stream_gen.sv
// Purpose: replays a stored sample pattern as valid-qualified bursts separated by idle gaps.
// Latency: first beat one cycle after an accepted start; all outputs registered.
// Backpressure: none; the consumer must accept every val_o beat.
module burst_stream_gen #(
    parameter int WORD_LEN  = 8,
    parameter int PAT_DEPTH = 16,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    burst_stream_gen_if.slave    bus
);
    localparam int AW = $clog2(PAT_DEPTH);
    localparam logic [AW:0] DEPTH_V = (AW+1)'(PAT_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;

    state_t              state_q, state_n;
    logic [AW-1:0]       ptr_q, ptr_n;
    logic [CNT_W-1:0]    beat_q, beat_n;
    logic [CNT_W-1:0]    burst_q, burst_n;
    logic [CNT_W-1:0]    gap_q, gap_n;
    logic [AW:0]         plen_q, plen_n;
    logic [CNT_W-1:0]    blen_q, blen_n;
    logic [CNT_W-1:0]    glen_q, glen_n;
    logic [CNT_W-1:0]    nb_q, nb_n;
    logic [WORD_LEN-1:0] dat_q, dat_n;
    logic                val_q, val_n;
    logic                busy_q, busy_n;
    logic                done_q, done_n;

    logic [WORD_LEN-1:0] mem [PAT_DEPTH];
    logic [AW-1:0]       rd_addr;
    logic [WORD_LEN-1:0] rd_dat;
    logic [AW:0]         plen_clamp;
    logic                wr_en;
    logic                last_beat, last_burst, last_gap, ptr_last;

    // Pattern writes are only honoured while no run is in progress.
    assign wr_en = bus.pat_we && (state_q == IDLE || state_q == FIN);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[bus.pat_addr] <= bus.pat_wdat;
        end
    end

    // Bypass so a write issued alongside start is seen by the first beat.
    assign rd_dat = (wr_en && bus.pat_addr == rd_addr) ? bus.pat_wdat : mem[rd_addr];

    always_comb begin
        plen_clamp = bus.pat_len;
        if (bus.pat_len == '0) begin
            plen_clamp = (AW+1)'(1);
        end else if (bus.pat_len > DEPTH_V) begin
            plen_clamp = DEPTH_V;
        end
    end

    // Compare against length-1 so an all-ones length never needs a wider counter.
    assign last_beat  = (beat_q  == blen_q - CNT_W'(1));
    assign last_burst = (burst_q == nb_q   - CNT_W'(1));
    assign last_gap   = (gap_q   == glen_q - CNT_W'(1));
    assign ptr_last   = ({1'b0, ptr_q} == plen_q - (AW+1)'(1));

    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        beat_n  = beat_q;
        burst_n = burst_q;
        gap_n   = gap_q;
        plen_n  = plen_q;
        blen_n  = blen_q;
        glen_n  = glen_q;
        nb_n    = nb_q;
        val_n   = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        rd_addr = '0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    plen_n = plen_clamp;
                    blen_n = bus.burst_len;
                    glen_n = bus.gap_len;
                    nb_n   = bus.num_bursts;
                    if (bus.burst_len == '0 || bus.num_bursts == '0) begin
                        state_n = FIN;
                        done_n  = 1'b1;
                    end else begin
                        state_n = RUN;
                        ptr_n   = '0;
                        beat_n  = '0;
                        burst_n = '0;
                        val_n   = 1'b1;
                        busy_n  = 1'b1;
                    end
                end
            end
            RUN: begin
                busy_n = 1'b1;
                if (last_beat) begin
                    if (last_burst) begin
                        state_n = FIN;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        burst_n = burst_q + CNT_W'(1);
                        beat_n  = '0;
                        ptr_n   = '0;
                        if (glen_q != '0) begin
                            state_n = GAP;
                            gap_n   = '0;
                        end else begin
                            val_n = 1'b1;
                        end
                    end
                end else begin
                    beat_n  = beat_q + CNT_W'(1);
                    ptr_n   = ptr_last ? '0 : ptr_q + AW'(1);
                    rd_addr = ptr_n;
                    val_n   = 1'b1;
                end
            end
            GAP: begin
                busy_n = 1'b1;
                if (last_gap) begin
                    state_n = RUN;
                    ptr_n   = '0;
                    beat_n  = '0;
                    val_n   = 1'b1;
                end else begin
                    gap_n = gap_q + CNT_W'(1);
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        dat_n = val_n ? rd_dat : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            beat_q  <= '0;
            burst_q <= '0;
            gap_q   <= '0;
            plen_q  <= '0;
            blen_q  <= '0;
            glen_q  <= '0;
            nb_q    <= '0;
            dat_q   <= '0;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            beat_q  <= beat_n;
            burst_q <= burst_n;
            gap_q   <= gap_n;
            plen_q  <= plen_n;
            blen_q  <= blen_n;
            glen_q  <= glen_n;
            nb_q    <= nb_n;
            dat_q   <= dat_n;
            val_q   <= val_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign bus.dat_o = dat_q;
    assign bus.val_o = val_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_burst_stream_gen.sv
// Directed bench for burst_stream_gen: bursts, gaps, back-to-back bursts, zero-length runs,
// ignored start/write while busy, mid-run reset, pat_len clamping and maximum burst length.
module tb_burst_stream_gen;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    burst_stream_gen_if #(.WORD_LEN(8), .PAT_DEPTH(16), .CNT_W(8)) bus ();

    burst_stream_gen #(.WORD_LEN(8), .PAT_DEPTH(16), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [7:0] d);
        chk({tag, "_val"},  32'(bus.val_o), 32'd1);
        chk({tag, "_dat"},  32'(bus.dat_o), 32'(d));
        chk({tag, "_busy"}, 32'(bus.busy),  32'd1);
        tick();
    endtask

    task automatic fin_check(input string tag);
        chk({tag, "_done"},  32'(bus.done),  32'd1);
        chk({tag, "_val"},   32'(bus.val_o), 32'd0);
        chk({tag, "_busy"},  32'(bus.busy),  32'd0);
        tick();
        chk({tag, "_done_clr"}, 32'(bus.done), 32'd0);
    endtask

    task automatic go(input logic [4:0] pl, input logic [7:0] bl, input logic [7:0] gl,
                      input logic [7:0] nb);
        bus.pat_len    = pl;
        bus.burst_len  = bl;
        bus.gap_len    = gl;
        bus.num_bursts = nb;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        logic [7:0] exp10 [10];
        logic [7:0] exp9  [9];
        logic [7:0] pat   [5];
        exp10 = '{8'd5, 8'd3, 8'd4, 8'd2, 8'd1, 8'd5, 8'd3, 8'd4, 8'd2, 8'd1};
        exp9  = '{8'd5, 8'd3, 8'd4, 8'd5, 8'd3, 8'd4, 8'd5, 8'd3, 8'd4};
        pat   = '{8'd5, 8'd3, 8'd4, 8'd2, 8'd1};

        rst = 1'b1;
        bus.pat_we = 1'b0; bus.pat_addr = '0; bus.pat_wdat = '0; bus.pat_len = '0;
        bus.burst_len = '0; bus.gap_len = '0; bus.num_bursts = '0; bus.start = 1'b0;
        repeat (3) tick();
        chk("rst_val",  32'(bus.val_o), 32'd0);
        chk("rst_dat",  32'(bus.dat_o), 32'd0);
        chk("rst_busy", 32'(bus.busy),  32'd0);
        chk("rst_done", 32'(bus.done),  32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            bus.pat_we = 1'b1; bus.pat_addr = 4'(i); bus.pat_wdat = pat[i];
            tick();
        end
        bus.pat_we = 1'b0;

        // 1: single 10-beat burst wrapping a 5-entry pattern
        bus.start = 1'b1;
        bus.pat_len = 5'd5; bus.burst_len = 8'd10; bus.gap_len = 8'd0; bus.num_bursts = 8'd1;
        chk("t1_pre_val", 32'(bus.val_o), 32'd0);
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) beat($sformatf("t1_b%0d", i), exp10[i]);
        fin_check("t1");

        // 2: two bursts with a 15-cycle gap
        go(5'd5, 8'd5, 8'd15, 8'd2);
        for (int i = 0; i < 5; i++) beat($sformatf("t2a_b%0d", i), exp10[i]);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("t2_gap%0d_val", i),  32'(bus.val_o), 32'd0);
            chk($sformatf("t2_gap%0d_dat", i),  32'(bus.dat_o), 32'd0);
            chk($sformatf("t2_gap%0d_busy", i), 32'(bus.busy),  32'd1);
            tick();
        end
        for (int i = 0; i < 5; i++) beat($sformatf("t2b_b%0d", i), exp10[i]);
        fin_check("t2");

        // 3: back-to-back bursts, pointer restarts each burst
        go(5'd5, 8'd3, 8'd0, 8'd3);
        for (int i = 0; i < 9; i++) beat($sformatf("t3_b%0d", i), exp9[i]);
        fin_check("t3");

        // 4: zero burst length
        chk("t4_pre_done", 32'(bus.done), 32'd0);
        go(5'd5, 8'd0, 8'd0, 8'd1);
        fin_check("t4");
        chk("t4_after_val", 32'(bus.val_o), 32'd0);

        // 5: start and write during beat 3 are ignored
        go(5'd5, 8'd10, 8'd0, 8'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                bus.start = 1'b1; bus.pat_we = 1'b1; bus.pat_addr = 4'd0; bus.pat_wdat = 8'd9;
            end
            beat($sformatf("t5_b%0d", i), exp10[i]);
            bus.start = 1'b0; bus.pat_we = 1'b0;
        end
        fin_check("t5");
        chk("t5_no_restart", 32'(bus.val_o), 32'd0);
        go(5'd5, 8'd1, 8'd0, 8'd1);
        beat("t5_mem0", 8'd5);
        fin_check("t5_mem0");

        // 6: reset on beat 4
        go(5'd5, 8'd10, 8'd0, 8'd1);
        for (int i = 0; i < 3; i++) beat($sformatf("t6_b%0d", i), exp10[i]);
        chk("t6_b3_dat", 32'(bus.dat_o), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_val",  32'(bus.val_o), 32'd0);
        chk("t6_rst_dat",  32'(bus.dat_o), 32'd0);
        chk("t6_rst_busy", 32'(bus.busy),  32'd0);
        chk("t6_rst_done", 32'(bus.done),  32'd0);
        tick();
        chk("t6_idle_done", 32'(bus.done),  32'd0);
        chk("t6_idle_val",  32'(bus.val_o), 32'd0);
        go(5'd5, 8'd2, 8'd0, 8'd1);
        beat("t6_re_b0", 8'd5);
        beat("t6_re_b1", 8'd3);
        fin_check("t6_re");

        // pat_len 0 behaves as 1
        go(5'd0, 8'd3, 8'd0, 8'd1);
        for (int i = 0; i < 3; i++) beat($sformatf("pl0_b%0d", i), 8'd5);
        fin_check("pl0");

        // maximum burst length with a maximum-count gap between two bursts
        go(5'd5, 8'd255, 8'd255, 8'd2);
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 255; i++) beat($sformatf("max%0d_b%0d", b, i), pat[i % 5]);
            if (b == 0) begin
                for (int i = 0; i < 255; i++) begin
                    chk($sformatf("max_gap%0d_val", i), 32'(bus.val_o), 32'd0);
                    tick();
                end
            end
        end
        fin_check("max");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
